pc_seq: RTL and testbench
=========================

PC_SEQ -- requirements
Module: pc_seq

Interface
REQ-001 SHALL have parameter INC, default 4: sequential PC increment in bytes.
REQ-002 SHALL have parameter ACK_TIMEOUT, default 16: maximum FETCH cycles to wait for imem_ack, range 1..255.
REQ-003 SHALL have port clk, input, 1: clock; all state updates on the falling edge, matching the PC register.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port start, input, 1: leave IDLE or HALT and begin fetching.
REQ-006 SHALL have port halt_req, input, 1: stop after the current instruction retires.
REQ-007 SHALL have port pc_cur, input, 32: current PC from the PC register.
REQ-008 SHALL have port imem_req, output, 1: instruction fetch request.
REQ-009 SHALL have port imem_ack, input, 1: fetch data valid.
REQ-010 SHALL have port instr_valid, output, 1: one-cycle pulse when a fetch is accepted.
REQ-011 SHALL have port exe_done, input, 1: level signal; the current instruction has finished executing.
REQ-012 SHALL have port stall, input, 1: holds retirement.
REQ-013 SHALL have port redirect, input, 1: taken branch or jump.
REQ-014 SHALL have port redirect_target, input, 32: branch or jump target.
REQ-015 SHALL have port pc_ena, output, 1: write enable to the PC register.
REQ-016 SHALL have port pc_next, output, 32: data to the PC register.
REQ-017 SHALL have port busy, output, 1: asserted in FETCH or EXEC.
REQ-018 SHALL have port halted, output, 1: asserted in HALT or FAULT.
REQ-019 SHALL have port fault, output, 1: asserted in FAULT only.
REQ-020 SHALL have port instr_count, output, 32: count of retired instructions.

Function
REQ-021 SHALL implement FSM states IDLE, FETCH, EXEC, HALT and FAULT.
REQ-022 IDLE: on start=1, go to FETCH; halt_req is ignored.
REQ-023 FETCH: imem_req=1; the timeout counter clears on FETCH entry and increments each cycle imem_ack=0.
REQ-024 FETCH, imem_ack=1 in FETCH cycle k, where k<=ACK_TIMEOUT: go to EXEC; instr_valid=1 for exactly the following EXEC-entry cycle.
REQ-025 FETCH, ACK_TIMEOUT cycles elapse with no ack: go to FAULT; imem_req deasserts.
REQ-026 EXEC: pc_ena = exe_done & ~stall, combinational, same cycle; stall dominates exe_done.
REQ-027 When pc_ena=1, pc_next SHALL be {redirect_target[31:2],2'b00} if redirect=1, else pc_cur+INC modulo 2^32; when pc_ena=0, pc_next SHALL equal pc_cur.
REQ-028 Retirement (pc_ena=1): instr_count increments, saturating at 32'hFFFFFFFF.
REQ-029 Retirement with halt_req=1 goes to HALT; retirement with halt_req=0 goes to FETCH.
REQ-030 halt_req asserted during FETCH, or during EXEC without retirement, SHALL NOT abort the instruction; it is sampled only at retirement.
REQ-031 HALT: on start=1, go to FETCH and resume at pc_cur; the PC is not modified.
REQ-032 FAULT: sticky, exited only by reset; pc_ena=0 and imem_req=0.
REQ-033 PC wrap: pc_cur=32'hFFFFFFFC with INC=4 SHALL give pc_next=32'h00000000, with no flag.
REQ-034 imem_ack outside FETCH SHALL be ignored; exe_done outside EXEC SHALL be ignored.

Reset
REQ-035 rst=0 SHALL immediately force IDLE, with imem_req, instr_valid, pc_ena, busy, halted and fault at 0, instr_count=0, timeout counter=0, and pc_next=pc_cur.
REQ-036 Reset asserted mid-FETCH or mid-EXEC SHALL abandon the instruction without a pc_ena pulse.
REQ-037 After rst deasserts, the block SHALL stay in IDLE until start=1.

Verification
REQ-038 Scenario: start, ack on FETCH cycle 2, exe_done=1, redirect=0, pc_cur=0x100 -> instr_valid pulse, one pc_ena pulse with pc_next=0x104, instr_count=1, back to FETCH.
REQ-039 Scenario: redirect=1, redirect_target=0x00400013 at retirement -> pc_next=0x00400010.
REQ-040 Scenario: exe_done=1 and stall=1 for 3 cycles, then stall=0 -> pc_ena=0 for those 3 cycles, then a single pc_ena pulse.
REQ-041 Scenario: no imem_ack for 16 cycles -> fault=1 and halted=1 on the next edge; only rst=0 clears them.
REQ-042 Scenario: halt_req pulsed in FETCH, then retirement with halt_req held -> HALT with halted=1; start then resumes at unchanged pc_cur.
REQ-043 Scenario: pc_cur=0xFFFFFFFC, retirement -> pc_next=0x00000000; rst=0 mid-EXEC -> all outputs at reset values asynchronously.

Source files
------------

// File: rtl/pc_seq.sv
// rtl/pc_seq.sv - PC sequencer: fetch/execute/retire control with ack timeout
// All state advances on the falling clock edge, in step with the external PC register.
module pc_seq #(
   parameter int unsigned INC         = 4,
   parameter int unsigned ACK_TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        halt_req,
   input  logic [31:0] pc_cur,
   output logic        imem_req,
   input  logic        imem_ack,
   output logic        instr_valid,
   input  logic        exe_done,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_target,
   output logic        pc_ena,
   output logic [31:0] pc_next,
   output logic        busy,
   output logic        halted,
   output logic        fault,
   output logic [31:0] instr_count
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_EXEC,
      S_HALT,
      S_FAULT
   } state_t;

   localparam logic [7:0]  TMO_LAST = 8'(ACK_TIMEOUT - 1);
   localparam logic [31:0] INC_W    = 32'(INC);

   state_t      state;
   state_t      state_nx;
   logic [7:0]  tmo_cnt;
   logic        valid_q;

   always_comb begin
      state_nx = state;
      imem_req = 1'b0;
      pc_ena   = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) state_nx = S_FETCH;
         end
         S_FETCH: begin
            imem_req = 1'b1;
            // tmo_cnt holds the number of ack-less cycles already elapsed
            if (imem_ack)                  state_nx = S_EXEC;
            else if (tmo_cnt == TMO_LAST)  state_nx = S_FAULT;
         end
         S_EXEC: begin
            pc_ena = exe_done & ~stall;
            if (pc_ena) state_nx = halt_req ? S_HALT : S_FETCH;
         end
         S_HALT: begin
            if (start) state_nx = S_FETCH;
         end
         S_FAULT: begin
            state_nx = S_FAULT;
         end
         default: begin
            state_nx = S_IDLE;
         end
      endcase
   end

   always_comb begin
      pc_next = pc_cur;
      if (pc_ena) begin
         if (redirect) pc_next = redirect_target & 32'hFFFF_FFFC;
         else          pc_next = pc_cur + INC_W;
      end
   end

   always_ff @(negedge clk or negedge rst) begin
      if (!rst) begin
         state       <= S_IDLE;
         tmo_cnt     <= 8'd0;
         valid_q     <= 1'b0;
         instr_count <= 32'd0;
      end else begin
         state   <= state_nx;
         valid_q <= (state == S_FETCH) && imem_ack;
         if (state == S_FETCH && state_nx == S_FETCH) tmo_cnt <= tmo_cnt + 8'd1;
         else                                         tmo_cnt <= 8'd0;
         if (pc_ena && instr_count != 32'hFFFF_FFFF) instr_count <= instr_count + 32'd1;
      end
   end

   assign instr_valid = valid_q;
   assign busy        = (state == S_FETCH) || (state == S_EXEC);
   assign halted      = (state == S_HALT) || (state == S_FAULT);
   assign fault       = (state == S_FAULT);

endmodule

// File: tb/tb_pc_seq.sv
// tb/tb_pc_seq.sv - scenario bench for pc_seq with a pc_next scoreboard
// Inputs change just after the falling (active) edge; outputs are sampled on the rising edge.
module tb_pc_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        start, halt_req, imem_ack, exe_done, stall, redirect;
   logic [31:0] pc_cur, redirect_target;
   logic        imem_req, instr_valid, pc_ena, busy, halted, fault;
   logic [31:0] pc_next, instr_count;

   int          pass_cnt = 0;
   int          total_cnt = 0;
   logic [31:0] exp_pc_q[$];
   logic [31:0] exp_count = 32'd0;
   logic [5:0]  flags;
   logic [31:0] exp_pc;

   always #5 clk = ~clk;

   pc_seq #(.INC(4), .ACK_TIMEOUT(16)) dut (
      .clk(clk), .rst(rst), .start(start), .halt_req(halt_req), .pc_cur(pc_cur),
      .imem_req(imem_req), .imem_ack(imem_ack), .instr_valid(instr_valid),
      .exe_done(exe_done), .stall(stall), .redirect(redirect),
      .redirect_target(redirect_target), .pc_ena(pc_ena), .pc_next(pc_next),
      .busy(busy), .halted(halted), .fault(fault), .instr_count(instr_count)
   );

   assign flags = {imem_req, instr_valid, pc_ena, busy, halted, fault};

   // every sampled pc_ena pulse must match the next expected retirement
   always @(posedge clk) begin
      if (rst === 1'b1 && pc_ena === 1'b1) begin
         total_cnt++;
         if (exp_pc_q.size() == 0) begin
            $display("FAIL sb_unexpected_pc_ena pc_next=%h required no pulse", pc_next);
         end else begin
            exp_pc = exp_pc_q.pop_front();
            if (pc_next !== exp_pc) $display("FAIL sb_pc_next got=%h required=%h", pc_next, exp_pc);
            else pass_cnt++;
         end
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic mid();
      @(posedge clk);
   endtask

   task automatic chk_flags(input string name, input logic [5:0] want);
      total_cnt++;
      if (flags !== want) $display("FAIL %s flags got=%b required=%b", name, flags, want);
      else pass_cnt++;
   endtask

   task automatic chk_count(input string name);
      total_cnt++;
      if (instr_count !== exp_count) $display("FAIL %s instr_count got=%0d required=%0d", name, instr_count, exp_count);
      else pass_cnt++;
   endtask

   // from FETCH entry: ack on cycle n, leaves the DUT in its first EXEC cycle
   task automatic fetch(input int n);
      for (int i = 1; i < n; i++) begin
         imem_ack = 1'b0;
         mid();
         tick();
      end
      imem_ack = 1'b1;
      mid();
      tick();
      imem_ack = 1'b0;
   endtask

   task automatic retire(input logic [31:0] pc_exp);
      exe_done = 1'b1;
      exp_pc_q.push_back(pc_exp);
      exp_count = exp_count + 32'd1;
      mid();
      tick();
      exe_done = 1'b0;
      pc_cur = pc_exp;
   endtask

   task automatic test_reset();
      rst = 1'b0; start = 0; halt_req = 0; imem_ack = 0; exe_done = 0; stall = 0;
      redirect = 0; redirect_target = 32'd0; pc_cur = 32'h0000_1234;
      #2;
      chk_flags("reset_flags", 6'b000000);
      chk_count("reset_count");
      total_cnt++;
      if (pc_next !== 32'h0000_1234) $display("FAIL reset_pc_next got=%h required=%h", pc_next, 32'h0000_1234);
      else pass_cnt++;
      tick();
      rst = 1'b1;
      imem_ack = 1'b1; exe_done = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      mid();
      chk_flags("idle_ignores_ack_exe", 6'b000000);
      tick();
      imem_ack = 1'b0; exe_done = 1'b0;
   endtask

   task automatic test_basic();
      pc_cur = 32'h0000_0100;
      start = 1'b1;
      tick();
      start = 1'b0;
      mid();
      chk_flags("basic_fetch1", 6'b100100);
      tick();
      imem_ack = 1'b1;
      mid();
      chk_flags("basic_fetch2", 6'b100100);
      tick();
      imem_ack = 1'b0;
      mid();
      chk_flags("basic_instr_valid", 6'b010100);
      tick();
      retire(32'h0000_0104);
      mid();
      chk_flags("basic_back_to_fetch", 6'b100100);
      chk_count("basic_count");
      tick();
   endtask

   task automatic test_redirect();
      fetch(1);
      redirect = 1'b1;
      redirect_target = 32'h0040_0013;
      retire(32'h0040_0010);
      redirect = 1'b0;
      mid();
      chk_flags("redirect_fetch", 6'b100100);
      chk_count("redirect_count");
      tick();
   endtask

   task automatic test_stall();
      fetch(3);
      exe_done = 1'b1;
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         mid();
         total_cnt++;
         if (pc_ena !== 1'b0 || pc_next !== pc_cur)
            $display("FAIL stall_hold cyc=%0d pc_ena=%b pc_next=%h required 0/%h", i, pc_ena, pc_next, pc_cur);
         else pass_cnt++;
         tick();
      end
      stall = 1'b0;
      retire(pc_cur + 32'd4);
      mid();
      chk_flags("stall_single_pulse", 6'b100100);
      chk_count("stall_count");
      tick();
   endtask

   task automatic test_halt();
      halt_req = 1'b1;
      mid();
      tick();
      halt_req = 1'b0;
      imem_ack = 1'b1;
      mid();
      tick();
      imem_ack = 1'b0;
      halt_req = 1'b1;
      mid();
      chk_flags("halt_exec_no_abort", 6'b010100);
      tick();
      mid();
      chk_flags("halt_exec_hold", 6'b000100);
      tick();
      retire(pc_cur + 32'd4);
      halt_req = 1'b0;
      mid();
      chk_flags("halt_state", 6'b000010);
      chk_count("halt_count");
      tick();
      imem_ack = 1'b1; exe_done = 1'b1;
      tick();
      tick();
      imem_ack = 1'b0; exe_done = 1'b0;
      mid();
      chk_flags("halt_sticky_until_start", 6'b000010);
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      mid();
      chk_flags("halt_resume", 6'b100100);
      total_cnt++;
      if (pc_next !== pc_cur) $display("FAIL halt_resume_pc got=%h required=%h", pc_next, pc_cur);
      else pass_cnt++;
      tick();
   endtask

   task automatic test_wrap_and_reset();
      fetch(1);
      pc_cur = 32'hFFFF_FFFC;
      retire(32'h0000_0000);
      mid();
      chk_count("wrap_count");
      tick();
      fetch(2);
      #2;
      rst = 1'b0;
      #1;
      exp_count = 32'd0;
      chk_flags("async_reset_flags", 6'b000000);
      chk_count("async_reset_count");
      exe_done = 1'b1;
      mid();
      chk_flags("reset_no_pc_ena", 6'b000000);
      tick();
      exe_done = 1'b0;
      rst = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      mid();
      chk_flags("post_reset_idle", 6'b000000);
      tick();
   endtask

   task automatic test_timeout();
      start = 1'b1;
      tick();
      start = 1'b0;
      fetch(16);
      mid();
      chk_flags("ack_on_last_cycle", 6'b010100);
      tick();
      retire(pc_cur + 32'd4);
      for (int i = 1; i <= 16; i++) begin
         mid();
         total_cnt++;
         if (fault !== 1'b0 || imem_req !== 1'b1)
            $display("FAIL timeout_wait cyc=%0d fault=%b imem_req=%b required 0/1", i, fault, imem_req);
         else pass_cnt++;
         tick();
      end
      mid();
      chk_flags("timeout_fault", 6'b000011);
      tick();
      start = 1'b1; imem_ack = 1'b1; exe_done = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      mid();
      chk_flags("fault_sticky", 6'b000011);
      tick();
      start = 1'b0; imem_ack = 1'b0; exe_done = 1'b0;
      rst = 1'b0;
      #1;
      exp_count = 32'd0;
      chk_flags("fault_cleared_by_reset", 6'b000000);
      tick();
      rst = 1'b1;
      tick();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_redirect();
      test_stall();
      test_halt();
      test_wrap_and_reset();
      test_timeout();
      total_cnt++;
      if (exp_pc_q.size() != 0) $display("FAIL sb_drain pending=%0d required=0", exp_pc_q.size());
      else pass_cnt++;
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
